// File: rtl/memory_stage.sv
// Memory stage: EX/MEM pipeline register, data-memory handshake with a
// variable-latency memory, and MEM/WB pipeline register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access outstanding beyond the current cycle
// ST_WAIT | request outstanding, memory has not answered yet; cnt_q
//         | holds the number of cycles already spent waiting
//
// The request is combinational from the EX/MEM register so that a
// zero-wait memory completes in the same cycle the instruction reaches M.
// A hung access is aborted once cnt_q reaches TIMEOUT; the instruction
// then retires as a bubble and the sticky MemErr flag is raised.
module memory_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic        MemReadE,
    input  logic [31:0] DMemRData,
    input  logic        DMemReady,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic        MemStall,
    output logic [31:0] ResultW,
    output logic [4:0]  WriteRegW,
    output logic        RegWriteW,
    output logic        MemErr
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // EX/MEM register
    logic [31:0] alu_out_m_q, alu_out_m_d;
    logic [31:0] write_data_m_q, write_data_m_d;
    logic [4:0]  write_reg_m_q, write_reg_m_d;
    logic        reg_write_m_q, reg_write_m_d;
    logic        memto_reg_m_q, memto_reg_m_d;
    logic        mem_write_m_q, mem_write_m_d;
    logic        mem_read_m_q, mem_read_m_d;

    // access FSM and wait counter
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // MEM/WB register and sticky error
    logic [31:0] result_w_q, result_w_d;
    logic [4:0]  write_reg_w_q, write_reg_w_d;
    logic        reg_write_w_q, reg_write_w_d;
    logic        mem_err_q, mem_err_d;

    // access qualification
    logic mem_op_m;
    logic misaligned;
    logic abort;
    logic dmem_req;
    logic mem_stall;

    // Request/stall decode; abort only exists in the last WAIT cycle when
    // the memory is still silent, so a late ready always wins.
    always_comb begin
        mem_op_m   = mem_read_m_q | mem_write_m_q;
        misaligned = mem_op_m & (alu_out_m_q[1:0] != 2'b00);
        abort      = (state_q == ST_WAIT) & ~DMemReady & (cnt_q == CNT_LIMIT);
        dmem_req   = mem_op_m & ~misaligned & ~abort;
        mem_stall  = dmem_req & ~DMemReady;
    end

    // EX/MEM next value: capture execute outputs unless the stage is frozen
    always_comb begin
        alu_out_m_d    = alu_out_m_q;
        write_data_m_d = write_data_m_q;
        write_reg_m_d  = write_reg_m_q;
        reg_write_m_d  = reg_write_m_q;
        memto_reg_m_d  = memto_reg_m_q;
        mem_write_m_d  = mem_write_m_q;
        mem_read_m_d   = mem_read_m_q;
        if (!mem_stall) begin
            alu_out_m_d    = ALUOutE;
            write_data_m_d = WriteDataE;
            write_reg_m_d  = WriteRegE;
            reg_write_m_d  = RegWriteE;
            memto_reg_m_d  = MemtoRegE;
            mem_write_m_d  = MemWriteE;
            mem_read_m_d   = MemReadE;
        end
    end

    // Access FSM next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (dmem_req && !DMemReady) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (DMemReady || abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB next value: stalls, aborts and misaligned ops retire as bubbles
    always_comb begin
        result_w_d    = result_w_q;
        write_reg_w_d = write_reg_w_q;
        reg_write_w_d = 1'b0;
        mem_err_d     = mem_err_q | abort | misaligned;
        if (!mem_stall && !abort && !misaligned) begin
            reg_write_w_d = reg_write_m_q;
            write_reg_w_d = write_reg_m_q;
            result_w_d    = memto_reg_m_q ? DMemRData : alu_out_m_q;
        end
    end

    // State registers; reset abandons any outstanding access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_m_q    <= '0;
            write_data_m_q <= '0;
            write_reg_m_q  <= '0;
            reg_write_m_q  <= 1'b0;
            memto_reg_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_read_m_q   <= 1'b0;
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            result_w_q     <= '0;
            write_reg_w_q  <= '0;
            reg_write_w_q  <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            alu_out_m_q    <= alu_out_m_d;
            write_data_m_q <= write_data_m_d;
            write_reg_m_q  <= write_reg_m_d;
            reg_write_m_q  <= reg_write_m_d;
            memto_reg_m_q  <= memto_reg_m_d;
            mem_write_m_q  <= mem_write_m_d;
            mem_read_m_q   <= mem_read_m_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_w_q     <= result_w_d;
            write_reg_w_q  <= write_reg_w_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign ALUOutM   = alu_out_m_q;
    assign WriteRegM = write_reg_m_q;
    assign RegWriteM = reg_write_m_q;
    assign MemtoRegM = memto_reg_m_q;
    assign DMemReq   = dmem_req;
    assign DMemWe    = mem_write_m_q;
    assign DMemAddr  = alu_out_m_q;
    assign DMemWData = write_data_m_q;
    assign MemStall  = mem_stall;
    assign ResultW   = result_w_q;
    assign WriteRegW = write_reg_w_q;
    assign RegWriteW = reg_write_w_q;
    assign MemErr    = mem_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios with literal expectations,
// then randomized instruction/memory-latency traffic against a
// transaction-level model of the stage.
module tb_memory_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUOutE, WriteDataE, DMemRData;
    logic [4:0]  WriteRegE;
    logic        RegWriteE, MemtoRegE, MemWriteE, MemReadE, DMemReady;
    logic [31:0] ALUOutM, DMemAddr, DMemWData, ResultW;
    logic [4:0]  WriteRegM, WriteRegW;
    logic        RegWriteM, MemtoRegM, DMemReq, DMemWe, MemStall, RegWriteW, MemErr;

    memory_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .MemReadE(MemReadE), .DMemRData(DMemRData), .DMemReady(DMemReady),
        .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .DMemReq(DMemReq), .DMemWe(DMemWe),
        .DMemAddr(DMemAddr), .DMemWData(DMemWData), .MemStall(MemStall),
        .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: instruction currently in M, how long it has been stalled,
    // the last retired result and the sticky error
    logic [31:0] m_alu, m_wd;
    logic [4:0]  m_wr;
    logic        m_rw, m_mtr, m_mw, m_mr;
    int          waited;
    logic [31:0] w_res;
    logic [4:0]  w_wr;
    logic        w_rw;
    logic        err;
    logic        e_mis, e_abort, e_req, e_stall;

    logic        last_stall, last_req, last_we;
    logic [31:0] last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_alu = '0; m_wd = '0; m_wr = '0;
        m_rw = 0; m_mtr = 0; m_mw = 0; m_mr = 0;
        waited = 0;
        w_res = '0; w_wr = '0; w_rw = 0;
        err = 0;
    endtask

    // What the memory port must look like this cycle for the op sitting in M
    task automatic model_comb();
        logic memop;
        memop   = m_mr | m_mw;
        e_mis   = memop && (m_alu[1:0] != 2'b00);
        e_abort = memop && !e_mis && (waited == TIMEOUT) && !DMemReady;
        e_req   = memop && !e_mis && !e_abort;
        e_stall = e_req && !DMemReady;
    endtask

    task automatic model_edge();
        model_comb();
        if (!e_stall && !e_abort && !e_mis) begin
            w_rw  = m_rw;
            w_wr  = m_wr;
            w_res = m_mtr ? DMemRData : m_alu;
        end else begin
            w_rw = 0;
        end
        if (e_abort || e_mis) err = 1;
        if (e_stall) begin
            waited++;
        end else begin
            waited = 0;
            m_alu = ALUOutE; m_wd = WriteDataE; m_wr = WriteRegE;
            m_rw = RegWriteE; m_mtr = MemtoRegE; m_mw = MemWriteE; m_mr = MemReadE;
        end
    endtask

    task automatic compare();
        model_comb();
        chk("ALUOutM",   ALUOutM,   m_alu);
        chk("WriteRegM", 32'(WriteRegM), 32'(m_wr));
        chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
        chk("MemtoRegM", 32'(MemtoRegM), 32'(m_mtr));
        chk("DMemReq",   32'(DMemReq),   32'(e_req));
        chk("DMemWe",    32'(DMemWe),    32'(m_mw));
        chk("DMemAddr",  DMemAddr,  m_alu);
        chk("DMemWData", DMemWData, m_wd);
        chk("MemStall",  32'(MemStall),  32'(e_stall));
        chk("ResultW",   ResultW,   w_res);
        chk("WriteRegW", 32'(WriteRegW), 32'(w_wr));
        chk("RegWriteW", 32'(RegWriteW), 32'(w_rw));
        chk("MemErr",    32'(MemErr),    32'(err));
        last_stall = MemStall;
        last_req   = DMemReq;
        last_we    = DMemWe;
        last_wdata = DMemWData;
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic cycle();
        #1;
        compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_e(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input logic rw, input logic mtr, input logic mw, input logic mr);
        ALUOutE = alu; WriteDataE = wd; WriteRegE = wr;
        RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw; MemReadE = mr;
    endtask

    task automatic set_nop();
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulled in the middle of the low clock phase
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_DMemReq",   32'(DMemReq),   32'h0);
        chk("rst_MemStall",  32'(MemStall),  32'h0);
        chk("rst_DMemWe",    32'(DMemWe),    32'h0);
        chk("rst_ALUOutM",   ALUOutM,        32'h0);
        chk("rst_DMemWData", DMemWData,      32'h0);
        chk("rst_RegWriteW", 32'(RegWriteW), 32'h0);
        chk("rst_ResultW",   ResultW,        32'h0);
        chk("rst_MemErr",    32'(MemErr),    32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs(input int mode);
        int op;
        logic [31:0] a;
        op = $urandom_range(0, 2);
        a  = $urandom;
        if (op != 0) begin
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            else a[1:0] = 2'b00;
        end
        set_e(a, $urandom, 5'($urandom),
              (op == 1) ? 1'b1 : ((op == 0) ? 1'($urandom_range(0, 1)) : 1'b0),
              op == 1, op == 2, op == 1);
        DMemRData = $urandom;
        case (mode)
            0, 1:    DMemReady = 1'b1;
            2, 3:    DMemReady = ($urandom_range(0, 2) == 0);
            default: DMemReady = 1'b0;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int mode;
        rst_n = 1'b0;
        set_nop();
        DMemReady = 1'b0;
        DMemRData = 32'h0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1 compare();
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op passes through untouched by memory
        set_e(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("t1_ALUOutM", ALUOutM, 32'h1234);
        set_nop();
        cycle();
        chk("t1_req", 32'(last_req), 32'h0);
        chk("t1_ResultW", ResultW, 32'h1234);
        chk("t1_RegWriteW", 32'(RegWriteW), 32'h1);
        chk("t1_WriteRegW", 32'(WriteRegW), 32'h5);

        // zero-wait load
        DMemReady = 1'b1;
        DMemRData = 32'hDEADBEEF;
        set_e(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        set_nop();
        cycle();
        chk("t2_req", 32'(last_req), 32'h1);
        chk("t2_stall", 32'(last_stall), 32'h0);
        chk("t2_ResultW", ResultW, 32'hDEADBEEF);
        chk("t2_RegWriteW", 32'(RegWriteW), 32'h1);
        cycle();
        chk("t2_req_drop", 32'(last_req), 32'h0);

        // store answered three cycles late; E side keeps changing meanwhile
        DMemReady = 1'b0;
        set_e(32'h40, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        set_e(32'h999, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (last_stall) n++;
            chk("t3_we", 32'(last_we), 32'h1);
            chk("t3_wdata", last_wdata, 32'hA5A5A5A5);
            chk("t3_RegWriteW", 32'(RegWriteW), 32'h0);
            set_e(32'h999, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("t3_stall_cycles", 32'(n), 32'd3);
        DMemReady = 1'b1;
        cycle();
        chk("t3_release_stall", 32'(last_stall), 32'h0);
        chk("t3_release_req", 32'(last_req), 32'h1);
        chk("t3_ALUOutM", ALUOutM, 32'h999);
        set_nop();
        cycle();
        chk("t3_ResultW", ResultW, 32'h999);
        chk("t3_RegWriteW", 32'(RegWriteW), 32'h1);

        // reset while the same store is waiting
        DMemReady = 1'b0;
        set_e(32'h40, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        set_e(32'h999, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        do_reset();

        // load that never completes: full timeout from a freshly reset counter
        set_e(32'h200, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        set_e(32'h77, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (!last_stall) break;
            n++;
        end
        chk("t4_stall_cycles", 32'(n), 32'd16);
        chk("t4_abort_req", 32'(last_req), 32'h0);
        chk("t4_MemErr", 32'(MemErr), 32'h1);
        chk("t4_RegWriteW", 32'(RegWriteW), 32'h0);
        chk("t4_next_ALUOutM", ALUOutM, 32'h77);
        set_nop();
        cycle();
        chk("t4_next_ResultW", ResultW, 32'h77);
        chk("t4_next_RegWriteW", 32'(RegWriteW), 32'h1);
        do_reset();

        // misaligned load
        DMemReady = 1'b1;
        set_e(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        set_nop();
        cycle();
        chk("t5_req", 32'(last_req), 32'h0);
        chk("t5_stall", 32'(last_stall), 32'h0);
        chk("t5_MemErr", 32'(MemErr), 32'h1);
        chk("t5_RegWriteW", 32'(RegWriteW), 32'h0);

        // randomized traffic with varying memory behaviour
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) mode = $urandom_range(0, 4);
            if (i == 1500) do_reset();
            rand_inputs(mode);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- EX/MEM pipeline register, data-memory access, and MEM/WB pipeline register. Consumes the execute stage's ALUOutE, WriteDataE and WriteRegE.
- Drives ALUOutM and ResultW back to the execute-stage forwarding muxes.
- Runs a request/ready handshake with a variable-latency data memory. Raises MemStall to freeze upstream stages while an access is outstanding.
- Aborts hung accesses with a timeout and rejects misaligned word accesses.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before an access is aborted (1..255)
CNT_W, 8, width of the wait counter; must hold TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ALUOutE  in  32  ALU result / memory address from execute
WriteDataE  in  32  store data from execute
WriteRegE  in  5  destination register from execute
RegWriteE  in  1  instruction writes register file
MemtoRegE  in  1  result comes from memory (load)
MemWriteE  in  1  store
MemReadE  in  1  load
DMemRData  in  32  memory read data, valid when DMemReady=1
DMemReady  in  1  memory completes the access this cycle
ALUOutM  out  32  registered ALU result (forwarding source)
WriteRegM  out  5  registered destination (hazard unit)
RegWriteM  out  1  registered write enable (hazard unit)
MemtoRegM  out  1  registered load flag (hazard unit)
DMemReq  out  1  access request
DMemWe  out  1  1 = write, 0 = read
DMemAddr  out  32  = ALUOutM
DMemWData  out  32  registered store data
MemStall  out  1  freeze PC/IF/ID/EX and the EX/MEM register
ResultW  out  32  writeback value
WriteRegW  out  5  writeback destination
RegWriteW  out  1  writeback enable
MemErr  out  1  sticky error: timeout or misaligned access

Behaviour:
- Reset:
  - All registers are 0. DMemReq, DMemWe, MemStall, RegWriteW and MemErr are 0.
  - FSM is in IDLE and the counter is 0.
  - Assertion of reset mid-access drops DMemReq immediately (asynchronous); the access is abandoned.
- Definitions:
  - MemOpM = MemReadM | MemWriteM.
  - Misaligned = MemOpM & (ALUOutM[1:0] != 0).
- EX/MEM register:
  - Captures all E-side inputs at a posedge when MemStall=0.
  - Holds its contents when MemStall=1.
  - Latency from E to M is 1 cycle.
- Request: DMemReq = MemOpM & ~Misaligned & ~Abort. DMemWe = MemWriteM. The request is held stable until DMemReady or Abort.
- Stall: MemStall = DMemReq & ~DMemReady. This is combinational; a zero-wait memory never stalls.
- FSM states:
  - IDLE: on DMemReq & ~DMemReady, go to WAIT and set counter to 1.
  - WAIT:
    - DMemReady: return to IDLE; the access completes this cycle.
    - Otherwise, if counter == TIMEOUT: Abort=1 for that cycle. DMemReq and MemStall drop, MemErr is set, FSM returns to IDLE. The instruction retires as a bubble.
    - Otherwise counter increments.
- Misaligned access:
  - No request is issued; MemErr is set at the next edge.
  - The instruction retires as a bubble with no stall.
- MEM/WB register, at each posedge:
  - MemStall=1: RegWriteW <= 0 (bubble).
  - Abort or Misaligned: RegWriteW <= 0.
  - Otherwise: RegWriteW <= RegWriteM, WriteRegW <= WriteRegM, ResultW <= MemtoRegM ? DMemRData : ALUOutM.
- MemErr is cleared only by reset.
- Back-to-back memory ops: the second op's request asserts in the cycle after the first completes. There is no idle gap beyond the EX/MEM advance.
- Simultaneous DMemReady and counter == TIMEOUT: ready wins and the access completes normally.

Test Plan:
1. ALU op (RegWriteE=1, WriteRegE=5, ALUOutE=0x1234): ALUOutM=0x1234 after 1 edge; ResultW=0x1234, RegWriteW=1, WriteRegW=5 after 2 edges; DMemReq never asserts.
2. Load at 0x100, DMemReady tied 1, DMemRData=0xDEADBEEF: DMemReq=1 for one cycle, MemStall stays 0, ResultW=0xDEADBEEF next edge.
3. Store at 0x40 with WriteDataE=0xA5A5A5A5, DMemReady arriving 3 cycles late: DMemReq/DMemWe/MemStall high for 3 cycles with DMemWData stable; RegWriteW=0 during the wait; E-side changes are ignored until release.
4. Load with DMemReady never asserted, TIMEOUT=16: MemStall high for 16 cycles, then drops; MemErr=1, RegWriteW=0, and the next instruction proceeds.
5. Load at 0x102: no DMemReq, MemStall=0, MemErr=1, RegWriteW=0.
6. rst_n pulled low during WAIT of scenario 3: DMemReq, MemStall and all outputs go to 0 immediately; after release, FSM is in IDLE with counter 0.
